// File: rtl/module_disp_scan_pkg.sv
// Shared definitions for the four-digit multiplexed display scanner.
//   N_DIGITS     : number of scanned digits
//   ANODE_OFF    : anode-enable word with every anode off (enables are active low)
//   scan_state_e : scan FSM state
//   anode_on()   : active-low enable word with only the given digit's anode on
package module_disp_scan_pkg;

    localparam int         N_DIGITS  = 4;
    localparam logic [7:0] ANODE_OFF = 8'hFF;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    function automatic logic [7:0] anode_on(input logic [1:0] digit);
        anode_on = ANODE_OFF ^ (8'h01 << digit);
    endfunction

endpackage

// File: rtl/module_disp_scan.sv
// Four-digit display scanner with blanking and a frame-synchronous data commit.
//
// Each digit slot is CLK_DIV cycles long. All anodes are off for the first
// BLANK_CYC cycles of the slot, and the selected digit's anode is on for the
// rest. A newly loaded word is held in a pending buffer. It is committed to
// data_o only at a frame boundary, so data_o never changes mid-frame.
//
// Ports
//   clk_i    in   system clock
//   rst_n_i  in   asynchronous reset, active low
//   data_i   in   [15:0] four nibbles, digit k = data_i[4k+3:4k]
//   load_i   in   single-cycle capture request for data_i
//   data_o   out  [15:0] committed display word (to the nibble mux)
//   sel_o    out  [1:0]  current digit index (to the nibble mux select)
//   en_o     out  [7:0]  active-low anode enables, [7:4] always 1
//   pend_o   out  a captured word is waiting for the next frame boundary
//   frame_o  out  high during the last cycle of each frame
//
// state | meaning
// ------+---------------------------------------------------------
// BLANK | all anodes off, lasts BLANK_CYC cycles, digit index may move
// SHOW  | anode of sel_o on, lasts CLK_DIV-BLANK_CYC cycles
module module_disp_scan
    import module_disp_scan_pkg::*;
#(
    parameter int CLK_DIV   = 10000,
    parameter int BLANK_CYC = 100
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] data_i,
    input  logic        load_i,
    output logic [15:0] data_o,
    output logic [1:0]  sel_o,
    output logic [7:0]  en_o,
    output logic        pend_o,
    output logic        frame_o
);

    if (BLANK_CYC < 1 || CLK_DIV < BLANK_CYC + 2) begin : g_bad_params
        $fatal(1, "module_disp_scan: need BLANK_CYC >= 1 and CLK_DIV >= BLANK_CYC + 2");
    end

    localparam int             CW         = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0]  SHOW_LAST  = CW'(CLK_DIV - BLANK_CYC - 1);
    localparam logic [1:0]     LAST_DIGIT = 2'(N_DIGITS - 1);

    scan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;
    logic [7:0]    en_q, en_d;
    logic          frame_q, frame_d;
    logic [15:0]   data_q, data_d;
    logic [15:0]   buf_q, buf_d;
    logic          pend_q, pend_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        digit_d = digit_q;
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    digit_d = digit_q + 2'd1;
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase

        // Enables and the frame flag are registered from the next-state values
        // so they line up with state_q/digit_q without any output decode.
        en_d    = (state_d == SHOW) ? anode_on(digit_d) : ANODE_OFF;
        frame_d = (state_d == SHOW) && (cnt_d == SHOW_LAST) && (digit_d == LAST_DIGIT);

        // frame_q is high exactly in the cycle whose closing edge ends the
        // frame, so it doubles as the commit strobe for the display word.
        data_d = data_q;
        buf_d  = buf_q;
        pend_d = pend_q;
        if (frame_q) begin
            if (load_i) begin
                data_d = data_i;
                pend_d = 1'b0;
            end else if (pend_q) begin
                data_d = buf_q;
                pend_d = 1'b0;
            end
        end else if (load_i) begin
            buf_d  = data_i;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            digit_q <= '0;
            en_q    <= ANODE_OFF;
            frame_q <= 1'b0;
            data_q  <= '0;
            buf_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            en_q    <= en_d;
            frame_q <= frame_d;
            data_q  <= data_d;
            buf_q   <= buf_d;
            pend_q  <= pend_d;
        end
    end

    assign data_o  = data_q;
    assign sel_o   = digit_q;
    assign en_o    = en_q;
    assign pend_o  = pend_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_module_disp_scan.sv
module tb_module_disp_scan;

    logic        clk_i   = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [15:0] data_i  = '0;
    logic        load_i  = 1'b0;

    logic [15:0] d_data  [2];
    logic [1:0]  d_sel   [2];
    logic [7:0]  d_en    [2];
    logic        d_pend  [2];
    logic        d_frame [2];

    module_disp_scan #(.CLK_DIV(8), .BLANK_CYC(2)) u_dut0 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .data_i  (data_i),
        .load_i  (load_i),
        .data_o  (d_data[0]),
        .sel_o   (d_sel[0]),
        .en_o    (d_en[0]),
        .pend_o  (d_pend[0]),
        .frame_o (d_frame[0])
    );

    module_disp_scan #(.CLK_DIV(3), .BLANK_CYC(1)) u_dut1 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .data_i  (data_i),
        .load_i  (load_i),
        .data_o  (d_data[1]),
        .sel_o   (d_sel[1]),
        .en_o    (d_en[1]),
        .pend_o  (d_pend[1]),
        .frame_o (d_frame[1])
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: t counts rising edges since reset release; all timing
    // follows from slot = t / CLK_DIV and position within the slot.
    int          t;
    int          div [2] = '{8, 3};
    int          blk [2] = '{2, 1};
    logic [15:0] m_disp [2];
    logic [15:0] m_buf  [2];
    logic        m_pend [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < 2; i++) begin
            m_disp[i] = '0;
            m_buf[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    function automatic bit last_of_frame(input int i, input int tt);
        return (tt % (4 * div[i])) == (4 * div[i] - 1);
    endfunction

    task automatic check_outputs();
        int         pos;
        int         dig;
        logic [7:0] en_exp;
        for (int i = 0; i < 2; i++) begin
            pos    = t % div[i];
            dig    = (t / div[i]) % 4;
            en_exp = (pos < blk[i]) ? 8'hFF : (8'hFF ^ (8'h01 << dig));
            chk($sformatf("en%0d", i), {24'h0, d_en[i]}, {24'h0, en_exp});
            chk($sformatf("en_hi%0d", i), {28'h0, d_en[i][7:4]}, 32'hF);
            chk($sformatf("sel%0d", i), {30'h0, d_sel[i]}, 32'(dig));
            chk($sformatf("frame%0d", i), {31'h0, d_frame[i]}, {31'h0, last_of_frame(i, t)});
            chk($sformatf("data%0d", i), {16'h0, d_data[i]}, {16'h0, m_disp[i]});
            chk($sformatf("pend%0d", i), {31'h0, d_pend[i]}, {31'h0, m_pend[i]});
        end
    endtask

    // One clock: inputs are already set; update model at the edge, check at negedge.
    task automatic step();
        @(posedge clk_i);
        for (int i = 0; i < 2; i++) begin
            if (last_of_frame(i, t)) begin
                if (load_i) begin
                    m_disp[i] = data_i;
                    m_pend[i] = 1'b0;
                end else if (m_pend[i]) begin
                    m_disp[i] = m_buf[i];
                    m_pend[i] = 1'b0;
                end
            end else if (load_i) begin
                m_buf[i]  = data_i;
                m_pend[i] = 1'b1;
            end
        end
        t++;
        @(negedge clk_i);
        check_outputs();
        load_i = 1'b0;
    endtask

    task automatic run_to(input int target);
        while ((t % 32) != target) step();
    endtask

    task automatic load_word(input logic [15:0] w);
        data_i = w;
        load_i = 1'b1;
        step();
    endtask

    initial begin
        model_reset();
        rst_n_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            check_outputs();
        end
        rst_n_i = 1'b1;
        model_reset();

        // free run: three frames of the base pattern
        repeat (96) step();

        // single load mid-frame, commit at the frame boundary
        run_to(5);
        load_word(16'h1234);
        run_to(31);
        step();

        // last load wins, then a load landing exactly on the boundary cycle
        run_to(3);
        load_word(16'hAAAA);
        run_to(9);
        load_word(16'h5555);
        run_to(31);
        step();
        run_to(31);
        load_word(16'hBEEF);

        // random loads, with extra weight on boundary cycles
        for (int n = 0; n < 800; n++) begin
            data_i = 16'($urandom);
            load_i = ($urandom_range(0, 9) == 0) ||
                     (((t % 32) == 31) && ($urandom_range(0, 1) == 0));
            step();
        end

        // asynchronous reset during SHOW of digit 2 with a word pending
        run_to(10);
        load_word(16'hC0DE);
        run_to(20);
        @(negedge clk_i);
        t++;
        check_outputs();
        #2;
        rst_n_i = 1'b0;
        model_reset();
        #1;
        check_outputs();
        repeat (2) begin
            @(negedge clk_i);
            check_outputs();
        end
        rst_n_i = 1'b1;
        repeat (40) step();

        for (int n = 0; n < 400; n++) begin
            data_i = 16'($urandom);
            load_i = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit in case the clock or stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/module_disp_scan.md
MODULE_DISP_SCAN -- requirements
Module: module_disp_scan

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter CLK_DIV, default 10000: clock cycles per digit slot (BLANK plus SHOW).
REQ-003 Parameter BLANK_CYC, default 100: cycles per slot with all anodes off.
REQ-004 clk_i  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_n_i  input  1  asynchronous reset, active low.
REQ-006 data_i  input  16  four BCD/hex nibbles to display; digit k = data_i[4k+3:4k].
REQ-007 load_i  input  1  single-cycle request to capture data_i.
REQ-008 data_o  output  16  committed display word; feeds the nibble-mux data input.
REQ-009 sel_o  output  2  current digit index; feeds the nibble-mux select input.
REQ-010 en_o  output  8  anode enables, active low; bits [7:4] SHALL always be 1.
REQ-011 pend_o  output  1  high while a captured word awaits commit.
REQ-012 frame_o  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 The FSM SHALL have exactly two states, BLANK and SHOW, and a cycle counter cnt.
- BLANK: en_o = 8'hFF; after BLANK_CYC cycles, go to SHOW with cnt = 0.
- SHOW: en_o[sel_o] = 0, all other bits 1; after CLK_DIV-BLANK_CYC cycles, go to BLANK with cnt = 0.
REQ-014 On SHOW->BLANK, digit SHALL increment; 3 wraps to 0.
REQ-015 sel_o SHALL change only on SHOW->BLANK; sel_o SHALL never change while any anode is enabled.
REQ-016 On SHOW->BLANK with digit==3 (frame boundary), frame_o SHALL be 1 for that single cycle.
REQ-017 Frame period SHALL be 4*CLK_DIV cycles.
REQ-018 On load_i=1, data_i SHALL be captured into a pending buffer and pend_o SHALL be set on the next cycle; multiple loads before commit: last one wins.
REQ-019 At a frame boundary with pend_o=1, the pending word SHALL be copied to data_o and pend_o cleared on the same edge; data_o SHALL never change mid-frame.
REQ-020 If load_i coincides with a frame boundary, data_i SHALL go directly to data_o and pend_o SHALL be 0 afterwards.
REQ-021 All outputs SHALL be registered; no combinational path from data_i/load_i to any output.
REQ-022 Legal parameters: BLANK_CYC >= 1, CLK_DIV >= BLANK_CYC+2. Illegal values SHALL be flagged by an elaboration-time assertion.
REQ-023 Counter width SHALL be $clog2(CLK_DIV) bits; cnt SHALL never exceed CLK_DIV-1.

Reset
REQ-024 While rst_n_i=0, outputs SHALL be: state BLANK, cnt 0, digit 0, sel_o 0, en_o 8'hFF, data_o 16'h0000, pending buffer 0, pend_o 0, frame_o 0.
REQ-025 Reset assertion mid-slot SHALL blank all anodes immediately (asynchronously) and discard any pending word.
REQ-026 After reset release, the first SHOW SHALL begin BLANK_CYC cycles later, on digit 0.

Structure
REQ-027 Shared package SHALL hold N_DIGITS=4, the anode-off constant 8'hFF, and the typedef enum {BLANK, SHOW} for the scan state.
REQ-028 There SHALL be no sub-module: one FSM, one counter, two 16-bit registers.
REQ-029 The display top SHALL instantiate module_disp_scan ahead of the nibble mux and the seven-segment decoder. The enable output SHALL come from this block, not from the decoder.

Verification (CLK_DIV=8, BLANK_CYC=2 unless stated)
REQ-030 Reset, then run free: en_o cycles FF(2) FE(6) FF(2) FD(6) FF(2) FB(6) FF(2) F7(6). sel_o = 0,1,2,3. frame_o pulses every 32 cycles.
REQ-031 Anode-change check: on every cycle where en_o != FF, sel_o equals the previous cycle's sel_o. en_o[7:4] is always 4'hF.
REQ-032 Pulse load_i with data_i=16'h1234 mid-frame: pend_o rises. data_o stays 0000 until the frame_o cycle, then becomes 1234 and pend_o falls.
REQ-033 Loads of 16'hAAAA then 16'h5555 in one frame: data_o becomes 5555 at the boundary. load_i with 16'hBEEF on the frame_o cycle: data_o = BEEF next cycle and pend_o = 0.
REQ-034 Assert rst_n_i asynchronously during SHOW of digit 2 with a word pending: en_o = FF immediately. data_o = 0000 and pend_o = 0. Restart on digit 0 after 2 blank cycles.
REQ-035 Parameter sweep {CLK_DIV=3, BLANK_CYC=1} and defaults: slot lengths exact. Illegal {CLK_DIV=3, BLANK_CYC=2} fails elaboration.
